sbox_fresh_prng: RTL and testbench
==================================

SBOX_FRESH_PRNG -- requirements
Module: sbox_fresh_prng

Interface
REQ-001: Parameter LANES, default 13, number of independent 15-bit LFSR lanes.
REQ-002: Parameter FRESH_WIDTH, default 195 (15*LANES), width of the Fresh bus driven into the d=4 HPC1 masked S-box.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: seed  input  15  seed word for the lane currently being loaded.
REQ-006: seed_valid  input  1  seed word present.
REQ-007: seed_ready  output  1  block accepts a seed word this cycle.
REQ-008: en  input  1  advance all lanes this cycle (only effective in RUN).
REQ-009: Fresh  output  FRESH_WIDTH  randomness; lane k drives Fresh[15k+14:15k], one 15-bit gadget slice per lane.
REQ-010: fresh_valid  output  1  Fresh carries seeded randomness.

Function
REQ-011: FSM has exactly two states, LOAD and RUN; no other states.
REQ-012: Seed word transfer occurs on a clock edge where seed_valid=1 and seed_ready=1.
REQ-013: LOAD: seed_ready=1, fresh_valid=0, Fresh=0; lane index counter idx (4 bits, 0..LANES-1) selects the target lane.
REQ-014: LOAD transfer: lane[idx] <= seed, except seed==15'h0000 loads 15'h0001 (lock-up avoidance); idx increments.
REQ-015: Transfer with idx==LANES-1: idx <= 0, FSM -> RUN on the same edge.
REQ-016: RUN: fresh_valid=1, Fresh = concatenation of lane registers (registered, no combinational path from inputs).
REQ-017: Lane step is Fibonacci, polynomial x^15+x^14+1: new = s[14]^s[13]; s <= {s[13:0], new}.
REQ-018: RUN with en=1: every lane advances exactly 15 steps per clock (unrolled); Fresh updates on the same edge.
REQ-019: RUN with en=0: all lanes hold; Fresh and fresh_valid stable.
REQ-020: RUN: seed_ready=0 while seed_valid=0; seed_valid=1 in RUN forces FSM -> LOAD on next edge with idx=0; that word is not consumed; fresh_valid=0 from that edge on.
REQ-021: Re-seed from RUN: lanes not yet reloaded keep prior contents but are never exposed (Fresh=0 in LOAD).
REQ-022: Lane value 15'h0000 is unreachable after any transfer; latency seed-accept to first valid Fresh = 1 clock after the 13th transfer.
REQ-023: en has no effect in LOAD; seed_valid while idx in range always accepted in LOAD (no back-pressure).

Reset
REQ-024: rst=0 asynchronously sets FSM=LOAD, idx=0, all lanes=15'h0001, fresh_valid=0, Fresh=0, seed_ready=1 (seed_ready held 0 while rst=0).
REQ-025: rst asserted mid-LOAD or mid-RUN discards all partial seeding; full 13-word load required after release.
REQ-026: First transfer permitted on the first rising edge with rst=1.

Verification
REQ-027: Reset, 13 transfers of 15'h0001 back-to-back -> fresh_valid=1 next cycle, every lane slice = 15'h0001; en=1 one cycle -> every slice = 15'h0003.
REQ-028: Seed word 15'h0000 at idx 4, others 15'h1234 -> in RUN slice Fresh[74:60]=15'h0001, all other slices 15'h1234.
REQ-029: RUN, en toggled 1,0,0,1 -> Fresh changes only on the two en=1 edges; slices match golden 15-step LFSR model each cycle.
REQ-030: RUN, seed_valid pulsed -> next cycle fresh_valid=0, Fresh=0, seed_ready=1, idx=0; 13 new words -> RUN with new seeds.
REQ-031: rst pulsed low after 7 transfers (gaps with seed_valid=0 inserted) -> asynchronous return to LOAD, idx=0; 13 further transfers needed before fresh_valid=1.
REQ-032: Period check, single lane seeded 15'h0001, en=1 -> slice returns to 15'h0001 after exactly 32767 cycles, never earlier.

Source files
------------

// File: rtl/sbox_fresh_prng.sv
// Fresh-randomness source for the d=4 HPC1 masked S-box: LANES independent 15-bit
// Fibonacci LFSRs, serially seeded one word per lane, each stepped 15 times per enabled clock.
module sbox_fresh_prng #(
  parameter int LANES       = 13,
  parameter int FRESH_WIDTH = 15 * LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [14:0]            seed,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  input  logic                   en,
  output logic [FRESH_WIDTH-1:0] Fresh,
  output logic                   fresh_valid
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(LANES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       idx;
  logic [3:0]       idx_nxt;
  logic [14:0]      lane     [LANES];
  logic [14:0]      lane_nxt [LANES];
  logic [FRESH_WIDTH-1:0] flat_nxt;

  // Fifteen unrolled steps of x^15+x^14+1, so a full fresh slice is replaced every clock.
  function automatic logic [14:0] step15(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    for (int i = 0; i < 15; i++) begin
      t = {t[13:0], t[14] ^ t[13]};
    end
    return t;
  endfunction

  // No seed is ever consumed outside LOAD; a seed_valid in RUN only triggers re-seeding.
  assign seed_ready = (state == LOAD) && rst;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    for (int k = 0; k < LANES; k++) begin
      lane_nxt[k] = lane[k];
    end
    if (state == LOAD) begin
      if (seed_valid) begin
        for (int k = 0; k < LANES; k++) begin
          if (idx == 4'(k)) begin
            lane_nxt[k] = (seed == 15'h0000) ? 15'h0001 : seed;
          end
        end
        if (idx == LAST_IDX) begin
          idx_nxt   = 4'd0;
          state_nxt = RUN;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
    end else if (seed_valid) begin
      state_nxt = LOAD;
      idx_nxt   = 4'd0;
    end else if (en) begin
      for (int k = 0; k < LANES; k++) begin
        lane_nxt[k] = step15(lane[k]);
      end
    end
  end

  always_comb begin
    flat_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      flat_nxt[15*k +: 15] = lane_nxt[k];
    end
  end

  // Fresh is registered and forced to zero outside RUN so stale lanes are never exposed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      idx         <= 4'd0;
      for (int k = 0; k < LANES; k++) begin
        lane[k] <= 15'h0001;
      end
      Fresh       <= '0;
      fresh_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      for (int k = 0; k < LANES; k++) begin
        lane[k] <= lane_nxt[k];
      end
      fresh_valid <= (state_nxt == RUN);
      Fresh       <= (state_nxt == RUN) ? flat_nxt : '0;
    end
  end

endmodule

// File: tb/tb_sbox_fresh_prng.sv
// Scoreboard bench for sbox_fresh_prng: a behavioural lane model pushes the expected
// outputs for every driven cycle, and each scenario pops and compares after the edge.
module tb_sbox_fresh_prng;

  localparam int LANES = 13;
  localparam int FW    = 15 * LANES;

  logic          clk;
  logic          rst;
  logic [14:0]   seed;
  logic          seed_valid;
  logic          seed_ready;
  logic          en;
  logic [FW-1:0] Fresh;
  logic          fresh_valid;

  typedef struct {
    logic          valid;
    logic          ready;
    logic [FW-1:0] fresh;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp;
  int          n_err;
  logic        m_load;
  int          m_idx;
  logic [14:0] m_lane [LANES];

  sbox_fresh_prng #(.LANES(LANES), .FRESH_WIDTH(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .en         (en),
    .Fresh      (Fresh),
    .fresh_valid(fresh_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Golden lane step: one shift of x^15+x^14+1, applied fifteen times per enabled clock.
  function automatic logic [14:0] lfsr_clock(input logic [14:0] s);
    logic [14:0] r;
    logic        fb;
    r = s;
    for (int n = 0; n < 15; n++) begin
      fb = r[14] ^ r[13];
      r  = (r << 1) | {14'd0, fb};
    end
    return r;
  endfunction

  task automatic model_reset();
    m_load = 1'b1;
    m_idx  = 0;
    for (int k = 0; k < LANES; k++) m_lane[k] = 15'h0001;
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.valid = !m_load;
    r.ready = m_load;
    r.fresh = '0;
    if (!m_load) begin
      for (int k = 0; k < LANES; k++) r.fresh[15*k +: 15] = m_lane[k];
    end
    return r;
  endfunction

  task automatic model_edge(input logic sv, input logic [14:0] s, input logic e_in);
    if (m_load) begin
      if (sv) begin
        m_lane[m_idx] = (s == 15'h0000) ? 15'h0001 : s;
        if (m_idx == LANES - 1) begin
          m_idx  = 0;
          m_load = 1'b0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (sv) begin
      m_load = 1'b1;
      m_idx  = 0;
    end else if (e_in) begin
      for (int k = 0; k < LANES; k++) m_lane[k] = lfsr_clock(m_lane[k]);
    end
  endtask

  task automatic apply_stimulus(input logic sv, input logic [14:0] s, input logic e_in);
    seed_valid = sv;
    seed       = s;
    en         = e_in;
    model_edge(sv, s, e_in);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    seed_valid = 1'b0;
    en         = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; seed = '0; seed_valid = 1'b0; en = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (fresh_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b, required 0", fresh_valid); end
    n_cmp++;
    if (Fresh !== '0) begin n_err++; $display("[TB] FAIL reset_fresh: got %h, required 0", Fresh); end
    n_cmp++;
    if (seed_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready_low: got %b, required 0", seed_ready); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (seed_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready_rel: got %b, required 1", seed_ready); end
  endtask

  task automatic test_load_ones();
    for (int i = 0; i < LANES; i++) begin
      apply_stimulus(1'b1, 15'h0001, 1'b0);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL load_ones[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
    apply_stimulus(1'b0, 15'h0000, 1'b1);
    e = sb.pop_front(); n_cmp++;
    if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
      n_err++;
      $display("[TB] FAIL ones_step: got valid=%b Fresh=%h, required valid=%b Fresh=%h", fresh_valid, Fresh, e.valid, e.fresh);
    end
    n_cmp++;
    if (Fresh !== {LANES{15'h0003}}) begin n_err++; $display("[TB] FAIL ones_step_const: got %h, required all slices 0003", Fresh); end
  endtask

  task automatic test_zero_seed();
    pulse_reset();
    for (int i = 0; i < LANES; i++) begin
      apply_stimulus(1'b1, (i == 4) ? 15'h0000 : 15'h1234, 1'b0);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL zero_seed[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
    for (int k = 0; k < LANES; k++) begin
      n_cmp++;
      if (Fresh[15*k +: 15] !== ((k == 4) ? 15'h0001 : 15'h1234)) begin
        n_err++;
        $display("[TB] FAIL zero_seed_slice%0d: got %h, required %h", k, Fresh[15*k +: 15], (k == 4) ? 15'h0001 : 15'h1234);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic pattern [6];
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 15'h0000, pattern[i]);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL en_toggle[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
  endtask

  task automatic test_reseed();
    apply_stimulus(1'b1, 15'h7777, 1'b1);
    e = sb.pop_front(); n_cmp++;
    if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
      n_err++;
      $display("[TB] FAIL reseed_enter: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
               fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
    end
    for (int i = 0; i < LANES; i++) begin
      apply_stimulus(1'b1, 15'(i * 16'h0101 + 5), i[0]);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL reseed_load[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
    apply_stimulus(1'b0, 15'h0000, 1'b1);
    e = sb.pop_front(); n_cmp++;
    if (Fresh !== e.fresh || fresh_valid !== e.valid) begin
      n_err++;
      $display("[TB] FAIL reseed_run: got valid=%b Fresh=%h, required valid=%b Fresh=%h", fresh_valid, Fresh, e.valid, e.fresh);
    end
  endtask

  task automatic test_reset_mid_load();
    // Mid-RUN reset first: outputs must clear without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (fresh_valid !== 1'b0 || Fresh !== '0 || seed_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL run_async_rst: got valid=%b ready=%b Fresh=%h, required 0 0 0", fresh_valid, seed_ready, Fresh);
    end
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(!i[0], 15'(16'h2000 + i), 1'b0);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL gap_load[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
    pulse_reset();
    for (int i = 0; i < LANES; i++) begin
      apply_stimulus(1'b1, 15'(16'h3100 + 3 * i), 1'b0);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid || seed_ready !== e.ready) begin
        n_err++;
        $display("[TB] FAIL reload[%0d]: got valid=%b ready=%b Fresh=%h, required valid=%b ready=%b Fresh=%h",
                 i, fresh_valid, seed_ready, Fresh, e.valid, e.ready, e.fresh);
      end
    end
  endtask

  task automatic test_period();
    int ret;
    pulse_reset();
    for (int i = 0; i < LANES; i++) begin
      apply_stimulus(1'b1, (i == 0) ? 15'h0001 : 15'h4321, 1'b0);
      e = sb.pop_front(); n_cmp++;
      if (Fresh !== e.fresh || fresh_valid !== e.valid) begin
        n_err++;
        $display("[TB] FAIL period_load[%0d]: got valid=%b Fresh=%h, required valid=%b Fresh=%h",
                 i, fresh_valid, Fresh, e.valid, e.fresh);
      end
    end
    ret = 0;
    seed_valid = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 32800; c++) begin
      @(posedge clk); #1;
      if (Fresh[14:0] === 15'h0001) begin
        ret = c;
        break;
      end
    end
    en = 1'b0;
    n_cmp++;
    if (ret != 32767) begin n_err++; $display("[TB] FAIL period: returned after %0d cycles, required 32767", ret); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load_ones();
    test_zero_seed();
    test_en_toggle();
    test_reseed();
    test_reset_mid_load();
    test_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
